// File: rtl/ceyloniac_pkg.sv
// Shared encodings and framing constants for the ceyloniac boot loader.
// Frame on the wire: N_LO, N_HI, N*4 payload bytes, XOR checksum byte.
package ceyloniac_pkg;

    typedef enum logic [2:0] {
        StHdrLo = 3'd0,
        StHdrHi = 3'd1,
        StData  = 3'd2,
        StWrite = 3'd3,
        StCsum  = 3'd4,
        StRun   = 3'd5,
        StError = 3'd6
    } boot_state_e;

    localparam int unsigned BOOT_HDR_BYTES = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_WIDTH     = 2;
    localparam int unsigned CSUM_WIDTH     = 8;

endpackage

// File: rtl/ceyloniac_byte_packer.sv
// Assembles little-endian bytes into one memory word; word_done_o flags the byte that completes it.
// word_o already includes the byte being accepted so the caller can register it on the same edge.
module ceyloniac_byte_packer
    import ceyloniac_pkg::*;
#(
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  byte_valid_i,
    input  logic [BYTE_WIDTH-1:0] byte_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_done_o
);

    logic [LANE_WIDTH-1:0] lane_q, lane_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;

    always_comb begin
        lane_d      = lane_q;
        word_d      = word_q;
        word_done_o = 1'b0;
        if (clear_i) begin
            lane_d = '0;
            word_d = '0;
        end else if (byte_valid_i) begin
            word_d[int'(lane_q)*BYTE_WIDTH +: BYTE_WIDTH] = byte_i;
            // Lane counter wraps to 0 after the last lane, ready for the next word.
            lane_d      = lane_q + 1'b1;
            word_done_o = (lane_q == LANE_WIDTH'(BYTES_PER_WORD - 1));
        end
    end

    assign word_o = word_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            word_q <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/ceyloniac_boot_loader.sv
// Boot loader: receives a framed program image, writes it through the load port, checks the
// XOR checksum and only then enables the control unit.
module ceyloniac_boot_loader
    import ceyloniac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BYTE_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [BYTE_WIDTH-1:0] rx_data_i,
    input  logic                  rx_valid_i,
    output logic                  rx_ready_o,
    input  logic                  boot_start_i,
    output logic                  load_mem_write_o,
    output logic [ADDR_WIDTH-1:0] load_mem_addr_o,
    output logic [DATA_WIDTH-1:0] load_mem_wdata_o,
    output logic                  control_enable_o,
    output logic                  boot_busy_o,
    output logic                  boot_error_o,
    output logic [ADDR_WIDTH:0]   words_loaded_o
);

    localparam int unsigned NW       = BOOT_HDR_BYTES * BYTE_WIDTH;
    localparam int unsigned MaxWords = 1 << ADDR_WIDTH;

    boot_state_e           state_q, state_d;
    logic [BYTE_WIDTH-1:0] n_lo_q, n_lo_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [BYTE_WIDTH-1:0] csum_q, csum_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  write_q, enable_q, busy_q, error_q;

    logic                  accept;
    logic                  pack_valid;
    logic                  word_done;
    logic [DATA_WIDTH-1:0] pack_word;
    logic [NW-1:0]         n_full;
    logic                  n_bad;
    logic [ADDR_WIDTH:0]   words_inc;

    assign rx_ready_o = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                        (state_q == StData)  || (state_q == StCsum);
    assign accept     = rx_valid_i && rx_ready_o;
    // A coincident boot_start drops the byte, so the packer must not see it either.
    assign pack_valid = accept && (state_q == StData) && !boot_start_i;
    assign n_full     = {rx_data_i, n_lo_q};
    assign n_bad      = (n_full == '0) || (32'(n_full) > MaxWords);
    assign words_inc  = words_q + 1'b1;

    ceyloniac_byte_packer #(
        .BYTE_WIDTH (BYTE_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (boot_start_i),
        .byte_valid_i (pack_valid),
        .byte_i       (rx_data_i),
        .word_o       (pack_word),
        .word_done_o  (word_done)
    );

    always_comb begin
        state_d = state_q;
        n_lo_d  = n_lo_q;
        n_d     = n_q;
        words_d = words_q;
        csum_d  = csum_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StHdrLo: begin
                if (accept) begin
                    n_lo_d  = rx_data_i;
                    csum_d  = csum_q ^ rx_data_i;
                    state_d = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data_i;
                    if (n_bad) begin
                        state_d = StError;
                    end else begin
                        n_d     = n_full[ADDR_WIDTH:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data_i;
                    if (word_done) begin
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        wdata_d = pack_word;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                words_d = words_inc;
                state_d = (words_inc == n_q) ? StCsum : StData;
            end
            StCsum: begin
                if (accept) begin
                    state_d = (rx_data_i == csum_q) ? StRun : StError;
                end
            end
            StRun, StError: state_d = state_q;
            default: state_d = StHdrLo;
        endcase

        if (boot_start_i) begin
            state_d = StHdrLo;
            n_lo_d  = '0;
            n_d     = '0;
            words_d = '0;
            csum_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StHdrLo;
            n_lo_q   <= '0;
            n_q      <= '0;
            words_q  <= '0;
            csum_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b1;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_lo_q   <= n_lo_d;
            n_q      <= n_d;
            words_q  <= words_d;
            csum_q   <= csum_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            // Status outputs follow the next state so they change on the same edge as the state.
            write_q  <= (state_d == StWrite);
            enable_q <= (state_d == StRun);
            busy_q   <= (state_d != StRun) && (state_d != StError);
            error_q  <= (state_d == StError);
        end
    end

    assign load_mem_write_o = write_q;
    assign load_mem_addr_o  = addr_q;
    assign load_mem_wdata_o = wdata_q;
    assign control_enable_o = enable_q;
    assign boot_busy_o      = busy_q;
    assign boot_error_o     = error_q;
    assign words_loaded_o   = words_q;

endmodule

// File: tb/tb_ceyloniac_boot_loader.sv
// Directed bench for ceyloniac_boot_loader: framing, checksum, header limits, stalls,
// re-boot and asynchronous reset.
module tb_ceyloniac_boot_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        boot_start_i = 1'b0;
    logic        load_mem_write_o;
    logic [7:0]  load_mem_addr_o;
    logic [31:0] load_mem_wdata_o;
    logic        control_enable_o;
    logic        boot_busy_o;
    logic        boot_error_o;
    logic [8:0]  words_loaded_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int base;
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    ceyloniac_boot_loader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .BYTE_WIDTH (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .rx_data_i        (rx_data_i),
        .rx_valid_i       (rx_valid_i),
        .rx_ready_o       (rx_ready_o),
        .boot_start_i     (boot_start_i),
        .load_mem_write_o (load_mem_write_o),
        .load_mem_addr_o  (load_mem_addr_o),
        .load_mem_wdata_o (load_mem_wdata_o),
        .control_enable_o (control_enable_o),
        .boot_busy_o      (boot_busy_o),
        .boot_error_o     (boot_error_o),
        .words_loaded_o   (words_loaded_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (load_mem_write_o) begin
            n_writes++;
            wr_addr.push_back(load_mem_addr_o);
            wr_data.push_back(load_mem_wdata_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) check("rx_ready_timeout", 32'(rx_ready_o), 32'd1);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic send_frame(input logic [7:0] csum, input int max_gap);
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h11223344, max_gap);
        send_word(32'hA5A5A5A5, max_gap);
        send_byte(csum);
    endtask

    task automatic pulse_boot();
        boot_start_i = 1'b1;
        @(negedge clk_i);
        boot_start_i = 1'b0;
    endtask

    task automatic check_frame_a_writes(input string tag);
        #1;
        check({tag, "_nwr"}, 32'(n_writes), 32'd2);
        if (wr_addr.size() == 2) begin
            check({tag, "_a0"}, 32'(wr_addr[0]), 32'd0);
            check({tag, "_d0"}, wr_data[0], 32'h11223344);
            check({tag, "_a1"}, 32'(wr_addr[1]), 32'd1);
            check({tag, "_d1"}, wr_data[1], 32'hA5A5A5A5);
        end
        wr_addr.delete();
        wr_data.delete();
        n_writes = 0;
    endtask

    initial begin
        logic [7:0]  c;
        logic [7:0]  b;
        logic [31:0] w;

        repeat (3) @(negedge clk_i);
        check("rst_ce",    32'(control_enable_o), 32'd0);
        check("rst_wr",    32'(load_mem_write_o), 32'd0);
        check("rst_addr",  32'(load_mem_addr_o),  32'd0);
        check("rst_wdata", load_mem_wdata_o,      32'd0);
        check("rst_busy",  32'(boot_busy_o),      32'd1);
        check("rst_err",   32'(boot_error_o),     32'd0);
        check("rst_words", 32'(words_loaded_o),   32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rdy_after_rst", 32'(rx_ready_o), 32'd1);

        // Frame A, back-to-back bytes; checksum 02^00^44^33^22^11^A5^A5^A5^A5 = 46.
        send_byte(8'h02);
        send_byte(8'h00);
        check("hdr_words", 32'(words_loaded_o), 32'd0);
        send_word(32'h11223344, 0);
        check("w0_strobe", 32'(load_mem_write_o), 32'd1);
        check("w0_addr",   32'(load_mem_addr_o),  32'd0);
        check("w0_data",   load_mem_wdata_o,      32'h11223344);
        check("w0_rdy",    32'(rx_ready_o),       32'd0);
        send_word(32'hA5A5A5A5, 0);
        check("a_pre_csum_ce", 32'(control_enable_o), 32'd0);
        send_byte(8'h46);
        check("a_ce",    32'(control_enable_o), 32'd1);
        check("a_rdy",   32'(rx_ready_o),       32'd0);
        check("a_words", 32'(words_loaded_o),   32'd2);
        check("a_busy",  32'(boot_busy_o),      32'd0);
        check("a_err",   32'(boot_error_o),     32'd0);
        check_frame_a_writes("a");

        // Re-boot from RUN, then the same frame with random gaps.
        pulse_boot();
        check("rb_ce",    32'(control_enable_o), 32'd0);
        check("rb_busy",  32'(boot_busy_o),      32'd1);
        check("rb_rdy",   32'(rx_ready_o),       32'd1);
        check("rb_words", 32'(words_loaded_o),   32'd0);
        send_frame(8'h46, 3);
        check("gap_ce", 32'(control_enable_o), 32'd1);
        check_frame_a_writes("gap");

        // Bad checksum.
        pulse_boot();
        send_frame(8'hB9, 0);
        check("bad_err",  32'(boot_error_o),     32'd1);
        check("bad_ce",   32'(control_enable_o), 32'd0);
        check("bad_busy", 32'(boot_busy_o),      32'd0);
        check("bad_rdy",  32'(rx_ready_o),       32'd0);
        idle(3);
        check("bad_err_sticky", 32'(boot_error_o), 32'd1);
        pulse_boot();
        check("clr_err",  32'(boot_error_o), 32'd0);
        check("clr_busy", 32'(boot_busy_o),  32'd1);
        check("clr_rdy",  32'(rx_ready_o),   32'd1);
        n_writes = 0;
        wr_addr.delete();
        wr_data.delete();

        // Header N=0 and N=257 are rejected without any write.
        send_byte(8'h00);
        send_byte(8'h00);
        check("n0_err", 32'(boot_error_o), 32'd1);
        check("n0_ce",  32'(control_enable_o), 32'd0);
        idle(3);
        #1;
        check("n0_nwr", 32'(n_writes), 32'd0);
        pulse_boot();
        send_byte(8'h01);
        send_byte(8'h01);
        check("n257_err", 32'(boot_error_o), 32'd1);
        idle(3);
        #1;
        check("n257_nwr", 32'(n_writes), 32'd0);
        pulse_boot();

        // Full-size image N=256.
        c = 8'h00 ^ 8'h01;
        send_byte(8'h00);
        send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            w = {b, ~b, b ^ 8'h5A, b};
            c = c ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            send_word(w, 0);
        end
        send_byte(c);
        check("max_ce",    32'(control_enable_o), 32'd1);
        check("max_words", 32'(words_loaded_o),   32'd256);
        #1;
        check("max_nwr", 32'(n_writes), 32'd256);
        if (wr_addr.size() == 256) begin
            check("max_last_addr", 32'(wr_addr[255]), 32'd255);
            check("max_last_data", wr_data[255], 32'hFF00A5FF);
            check("max_first_data", wr_data[0], 32'h00FF5A00);
        end

        // boot_start coincident with the 4th payload byte drops the write.
        pulse_boot();
        base = n_writes;
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'hDE);
        send_byte(8'hAD);
        send_byte(8'hBE);
        rx_data_i    = 8'hEF;
        rx_valid_i   = 1'b1;
        boot_start_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i   = 1'b0;
        boot_start_i = 1'b0;
        check("co_wr",    32'(load_mem_write_o), 32'd0);
        check("co_rdy",   32'(rx_ready_o),       32'd1);
        check("co_words", 32'(words_loaded_o),   32'd0);
        check("co_busy",  32'(boot_busy_o),      32'd1);
        idle(2);
        #1;
        check("co_nwr", 32'(n_writes), base);

        // Fresh N=1 frame after the aborted one; checksum 01^00^DE^AD^BE^EF = 23.
        send_byte(8'h01);
        send_byte(8'h00);
        send_word(32'hEFBEADDE, 0);
        send_byte(8'h23);
        check("n1_ce", 32'(control_enable_o), 32'd1);
        #1;
        check("n1_nwr", 32'(n_writes), base + 1);
        check("n1_data", wr_data[wr_data.size()-1], 32'hEFBEADDE);
        check("n1_addr", 32'(wr_addr[wr_addr.size()-1]), 32'd0);

        // Asynchronous reset in the middle of the second word.
        pulse_boot();
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(32'h01020304, 0);
        send_byte(8'h55);
        send_byte(8'h66);
        check("mid_words", 32'(words_loaded_o), 32'd1);
        #1;
        base = n_writes;
        #1;
        rst_ni = 1'b0;
        #1;
        check("ar_ce",    32'(control_enable_o), 32'd0);
        check("ar_wr",    32'(load_mem_write_o), 32'd0);
        check("ar_busy",  32'(boot_busy_o),      32'd1);
        check("ar_err",   32'(boot_error_o),     32'd0);
        check("ar_words", 32'(words_loaded_o),   32'd0);
        check("ar_addr",  32'(load_mem_addr_o),  32'd0);
        check("ar_wdata", load_mem_wdata_o,      32'd0);
        idle(2);
        rst_ni = 1'b1;
        idle(4);
        #1;
        check("ar_nwr", 32'(n_writes), base);
        check("ar_rdy", 32'(rx_ready_o), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
